// File: rtl/hdmi_in_roi_capture.sv
// hdmi_in_roi_capture: rebuilds pixel/line coordinates from a decoded HDMI
// input stream, crops a per-frame ROI window and streams the ROI pixels out
// through a first-word-fall-through FIFO. Also flags lines whose active
// length differs from IMG_WIDTH.
module hdmi_in_roi_capture #(
    parameter int unsigned IMG_WIDTH  = 1280,
    parameter int unsigned IMG_HEIGHT = 720,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic        hdmi_pclk,
    input  logic        s_rst_n,
    input  logic [23:0] hdmi_data,
    input  logic        hdmi_hs,
    input  logic        hdmi_vs,
    input  logic        hdmi_de,
    input  logic        roi_en,
    input  logic [15:0] roi_x,
    input  logic [15:0] roi_y,
    input  logic [15:0] roi_w,
    input  logic [15:0] roi_h,
    output logic [23:0] m_data,
    output logic        m_sof,
    output logic        m_eol,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        frame_done,
    output logic        ovf,
    output logic        timing_err
);
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] X_LAST   = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] Y_LAST   = 16'(IMG_HEIGHT - 1);
    localparam logic [15:0] X_FULL   = 16'(IMG_WIDTH);
    localparam logic [15:0] Y_FULL   = 16'(IMG_HEIGHT);
    localparam logic [AW:0] OCC_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    // hs carries no information this block needs
    logic unused_hs;
    assign unused_hs = hdmi_hs;

    // ---------------- stage 1: input registers ----------------
    logic [23:0] data_r1_q;
    logic        vs_r1_q, vs_r2_q, de_r1_q, de_r2_q;
    logic        sof, de_fall;

    // register the input stream once; the second vs/de stage only feeds edge detection
    always_ff @(posedge hdmi_pclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            data_r1_q <= '0;
            vs_r1_q   <= 1'b0;
            vs_r2_q   <= 1'b0;
            de_r1_q   <= 1'b0;
            de_r2_q   <= 1'b0;
        end else begin
            data_r1_q <= hdmi_data;
            vs_r1_q   <= hdmi_vs;
            vs_r2_q   <= vs_r1_q;
            de_r1_q   <= hdmi_de;
            de_r2_q   <= de_r1_q;
        end
    end

    assign sof     = vs_r1_q & ~vs_r2_q;
    assign de_fall = de_r2_q & ~de_r1_q;

    // ---------------- coordinates and line-length check ----------------
    logic [15:0] x_q, y_q;
    logic        timing_err_q;

    // x = column of the current stage-1 pixel; at a DE fall x holds the line length
    always_ff @(posedge hdmi_pclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            x_q          <= '0;
            y_q          <= '0;
            timing_err_q <= 1'b0;
        end else begin
            timing_err_q <= de_fall && (x_q != X_FULL);
            if (sof) begin
                x_q <= '0;
                y_q <= '0;
            end else if (de_fall) begin
                x_q <= '0;
                if (y_q != '1) y_q <= y_q + 16'd1;
            end else if (de_r1_q && x_q != '1) begin
                x_q <= x_q + 16'd1;
            end
        end
    end

    // ---------------- ROI window ----------------
    logic [16:0] xe_sum, ye_sum;
    logic [15:0] xe_d, ye_d;
    logic        roi_empty_d;
    logic [15:0] x0_q, y0_q, xe_q, ye_q;
    logic        roi_empty_q;

    // window end points in 17 bits so x+w cannot wrap, then clipped to the image
    always_comb begin
        xe_sum      = {1'b0, roi_x} + {1'b0, roi_w} - 17'd1;
        ye_sum      = {1'b0, roi_y} + {1'b0, roi_h} - 17'd1;
        xe_d        = (xe_sum > {1'b0, X_LAST}) ? X_LAST : xe_sum[15:0];
        ye_d        = (ye_sum > {1'b0, Y_LAST}) ? Y_LAST : ye_sum[15:0];
        roi_empty_d = (roi_w == '0) || (roi_h == '0) || (roi_x >= X_FULL) || (roi_y >= Y_FULL);
    end

    // latch the window once per frame at SOF
    always_ff @(posedge hdmi_pclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            x0_q        <= '0;
            y0_q        <= '0;
            xe_q        <= '0;
            ye_q        <= '0;
            roi_empty_q <= 1'b0;
        end else if (sof) begin
            x0_q        <= roi_x;
            y0_q        <= roi_y;
            xe_q        <= xe_d;
            ye_q        <= ye_d;
            roi_empty_q <= roi_empty_d;
        end
    end

    logic in_roi, sof_tag, eol_tag;

    // in-window test on the stage-1 pixel
    always_comb begin
        in_roi  = de_r1_q && !roi_empty_q && (y_q < Y_FULL) &&
                  (x_q >= x0_q) && (x_q <= xe_q) && (y_q >= y0_q) && (y_q <= ye_q);
        sof_tag = (x_q == x0_q) && (y_q == y0_q);
        eol_tag = (x_q == xe_q);
    end

    // ---------------- FSM ----------------
    state_t state_q, state_d;
    logic   capture_act, done_fire, drained, nopulse_q;
    logic   push_q, fifo_empty_q, m_valid_q;

    assign drained = fifo_empty_q && !m_valid_q && !push_q;

    // state register
    always_ff @(posedge hdmi_pclk or negedge s_rst_n) begin
        if (!s_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // next state; an SOF outside IDLE re-arms on the new window without flushing
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sof && roi_en) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (sof) state_d = roi_en ? CAPTURE : DRAIN;
                else if (de_fall && (roi_empty_q || y_q == ye_q)) state_d = DRAIN;
            end
            DRAIN: begin
                if (sof) state_d = roi_en ? CAPTURE : DRAIN;
                else if (drained) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        capture_act = (state_q == CAPTURE);
        done_fire   = (state_q == DRAIN) && !sof && drained && !nopulse_q;
    end

    // ---------------- stage 2: push ----------------
    logic [25:0] push_word_q;

    // registered push of {sof, eol, data}
    always_ff @(posedge hdmi_pclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            push_q      <= 1'b0;
            push_word_q <= '0;
        end else begin
            push_q      <= in_roi && capture_act;
            push_word_q <= {sof_tag, eol_tag, data_r1_q};
        end
    end

    // ---------------- FIFO with registered output word ----------------
    // occ counts memory entries plus the output register, so FIFO_DEPTH is the
    // total number of pixels held before drops start.
    logic [25:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ_q, occ_d;
    logic        fifo_full_q, wr_en, rd_en, pop_out;
    logic [25:0] m_word_q;

    // pointer and occupancy arithmetic
    always_comb begin
        wr_en    = push_q && !fifo_full_q;
        rd_en    = !fifo_empty_q && (!m_valid_q || m_ready);
        pop_out  = m_valid_q && m_ready;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
        occ_d    = occ_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop_out};
    end

    // storage array, no reset needed
    always_ff @(posedge hdmi_pclk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_word_q;
    end

    // pointers, registered flags and the output stage
    always_ff @(posedge hdmi_pclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            fifo_full_q  <= 1'b0;
            fifo_empty_q <= 1'b1;
            m_valid_q    <= 1'b0;
            m_word_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            fifo_full_q  <= (occ_d == OCC_FULL);
            fifo_empty_q <= (wr_ptr_d == rd_ptr_d);
            if (rd_en) begin
                m_word_q  <= mem_q[rd_ptr_q[AW-1:0]];
                m_valid_q <= 1'b1;
            end else if (pop_out) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    // ---------------- status ----------------
    logic ovf_q, frame_done_q;

    // sticky overflow, completion pulse, and pulse suppression after an abandoned frame
    always_ff @(posedge hdmi_pclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            ovf_q        <= 1'b0;
            frame_done_q <= 1'b0;
            nopulse_q    <= 1'b0;
        end else begin
            ovf_q        <= (ovf_q & ~sof) | (push_q & fifo_full_q);
            frame_done_q <= done_fire;
            if (sof) nopulse_q <= (state_q != IDLE) && !roi_en;
        end
    end

    assign m_data     = m_word_q[23:0];
    assign m_eol      = m_word_q[24];
    assign m_sof      = m_word_q[25];
    assign m_valid    = m_valid_q;
    assign frame_done = frame_done_q;
    assign ovf        = ovf_q;
    assign timing_err = timing_err_q;

endmodule

// File: tb/tb_hdmi_in_roi_capture.sv
// Self-checking bench for hdmi_in_roi_capture on a reduced image size.
`timescale 1ns/1ps
module tb_hdmi_in_roi_capture;
    localparam int W = 48, H = 20, D = 16, HBL = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] hdmi_data;
    logic        hdmi_hs, hdmi_vs, hdmi_de, roi_en;
    logic [15:0] roi_x, roi_y, roi_w, roi_h;
    logic [23:0] m_data;
    logic        m_sof, m_eol, m_valid, m_ready, frame_done, ovf, timing_err;

    hdmi_in_roi_capture #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D)) dut (
        .hdmi_pclk(clk), .s_rst_n(rst_n), .hdmi_data(hdmi_data), .hdmi_hs(hdmi_hs),
        .hdmi_vs(hdmi_vs), .hdmi_de(hdmi_de), .roi_en(roi_en), .roi_x(roi_x),
        .roi_y(roi_y), .roi_w(roi_w), .roi_h(roi_h), .m_data(m_data), .m_sof(m_sof),
        .m_eol(m_eol), .m_valid(m_valid), .m_ready(m_ready), .frame_done(frame_done),
        .ovf(ovf), .timing_err(timing_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [23:0] pix [H][W];
    int lens [H];
    logic [25:0] exp_q [$];
    logic [25:0] got [$];
    int cyc = 0, fd_cnt = 0, fd_cyc = 0, te_cnt = 0, te_cyc = 0, last_beat_cyc = 0, stab_bad = 0;
    int ready_mode = 0;   // 0: always ready, 1: never ready, 2: random
    int mark_line = -1, mark_cyc = 0;

    task automatic step;
        @(posedge clk); #1;
    endtask

    // downstream ready driver
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'b0;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // output monitor: collects beats and pulse events, tracks hold stability
    initial begin
        logic pv, pr;
        logic [25:0] pw;
        pv = 1'b0; pr = 1'b0; pw = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && pv && !pr && (!m_valid || {m_sof, m_eol, m_data} != pw)) stab_bad++;
            pv = m_valid; pr = m_ready; pw = {m_sof, m_eol, m_data};
            if (m_valid && m_ready) begin got.push_back(pw); last_beat_cyc = cyc; end
            if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
            if (timing_err) begin te_cnt++; te_cyc = cyc; end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    task automatic clear_obs;
        got.delete(); exp_q.delete();
        fd_cnt = 0; te_cnt = 0;
        for (int i = 0; i < H; i++) lens[i] = W;
    endtask

    // one frame: vs pulse, then nlines lines of lens[] active pixels each
    task automatic drive_frame(input bit en, input int rx, input int ry, input int rw,
                               input int rh, input int nlines);
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) pix[yy][xx] = 24'($urandom);
        roi_en = en; roi_x = 16'(rx); roi_y = 16'(ry); roi_w = 16'(rw); roi_h = 16'(rh);
        hdmi_vs = 1'b1;
        repeat (3) step;
        hdmi_vs = 1'b0;
        repeat (4) step;
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < lens[l]; p++) begin
                hdmi_de = 1'b1; hdmi_hs = 1'b0; hdmi_data = pix[l][p];
                step;
            end
            hdmi_de = 1'b0; hdmi_hs = 1'b1; hdmi_data = '0;
            if (l == mark_line) mark_cyc = cyc;
            repeat (HBL) step;
        end
        hdmi_hs = 1'b0;
        repeat (10) step;
    endtask

    // reference: every driven pixel inside the clipped window, row-major
    task automatic model_frame(input bit en, input int rx, input int ry, input int rw,
                               input int rh, input int nlines);
        int xe, ye;
        if (!en || rw == 0 || rh == 0 || rx >= W || ry >= H) return;
        xe = (rx + rw - 1 > W - 1) ? W - 1 : rx + rw - 1;
        ye = (ry + rh - 1 > H - 1) ? H - 1 : ry + rh - 1;
        for (int yy = ry; yy <= ye && yy < nlines; yy++)
            for (int xx = rx; xx <= xe && xx < lens[yy]; xx++)
                exp_q.push_back({(xx == rx && yy == ry), (xx == xe), pix[yy][xx]});
    endtask

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while (got.size() < exp_q.size() && t < budget) begin step; t++; end
        repeat (8) step;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        hdmi_data = '0; hdmi_hs = 1'b0; hdmi_vs = 1'b0; hdmi_de = 1'b0;
        roi_en = 1'b0; roi_x = '0; roi_y = '0; roi_w = '0; roi_h = '0;
        repeat (3) step;
        n_cmp++;
        if ({m_valid, m_sof, m_eol, frame_done, ovf, timing_err} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b required 000000",
                     {m_valid, m_sof, m_eol, frame_done, ovf, timing_err});
        end
        n_cmp++;
        if (m_data !== 24'h0) begin n_bad++; $display("FAIL reset_data: got %h required 0", m_data); end
        rst_n = 1'b1;
        repeat (4) step;
        n_cmp++;
        if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_idle_valid: got %b required 0", m_valid); end
    endtask

    task automatic test_basic;
        clear_obs(); ready_mode = 0;
        drive_frame(1, 5, 3, 8, 4, H);
        model_frame(1, 5, 3, 8, 4, H);
        wait_drain(3000);
        n_cmp++;
        if (got.size() !== 32) begin n_bad++; $display("FAIL basic_count: got %0d required 32", got.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL basic_beat[%0d]: got %h required %h", i, got[i], exp_q[i]); end
        end
        n_cmp++;
        if (fd_cnt !== 1 || fd_cyc <= last_beat_cyc) begin
            n_bad++; $display("FAIL basic_done: got %0d pulses at %0d (last beat %0d) required 1 after", fd_cnt, fd_cyc, last_beat_cyc);
        end
        n_cmp++;
        if (ovf !== 1'b0 || te_cnt !== 0) begin n_bad++; $display("FAIL basic_status: got ovf=%b te=%0d required 0/0", ovf, te_cnt); end
    endtask

    task automatic test_random;
        for (int f = 0; f < 5; f++) begin
            bit en;
            int rx, ry, rw, rh;
            clear_obs(); ready_mode = 2;
            en = ($urandom_range(0, 4) != 0);
            rx = int'($urandom_range(0, W + 3)); ry = int'($urandom_range(0, H + 1));
            rw = int'($urandom_range(0, 10));    rh = int'($urandom_range(0, 3));
            drive_frame(en, rx, ry, rw, rh, H);
            model_frame(en, rx, ry, rw, rh, H);
            wait_drain(3000);
            n_cmp++;
            if (got.size() !== exp_q.size()) begin
                n_bad++; $display("FAIL rand%0d_count: got %0d required %0d (roi %0d,%0d,%0d,%0d en=%0d)", f, got.size(), exp_q.size(), rx, ry, rw, rh, en);
            end
            for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
                n_cmp++;
                if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand%0d_beat[%0d]: got %h required %h", f, i, got[i], exp_q[i]); end
            end
            n_cmp++;
            if (fd_cnt !== (en ? 1 : 0)) begin n_bad++; $display("FAIL rand%0d_done: got %0d required %0d", f, fd_cnt, en ? 1 : 0); end
            n_cmp++;
            if (ovf !== 1'b0) begin n_bad++; $display("FAIL rand%0d_ovf: got %b required 0", f, ovf); end
        end
    endtask

    task automatic test_clip;
        clear_obs(); ready_mode = 0;
        drive_frame(1, W - 4, H - 3, 32, 32, H);
        model_frame(1, W - 4, H - 3, 32, 32, H);
        wait_drain(3000);
        n_cmp++;
        if (got.size() !== 12) begin n_bad++; $display("FAIL clip_count: got %0d required 12", got.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL clip_beat[%0d]: got %h required %h", i, got[i], exp_q[i]); end
        end
        n_cmp++;
        if (fd_cnt !== 1 || fd_cyc - last_beat_cyc < 1 || fd_cyc - last_beat_cyc > 3) begin
            n_bad++; $display("FAIL clip_done: got %0d pulses, %0d cycles after last beat, required 1 within 1..3", fd_cnt, fd_cyc - last_beat_cyc);
        end
    endtask

    task automatic test_overflow;
        clear_obs(); ready_mode = 1;
        drive_frame(1, 0, 0, 40, 2, H);
        model_frame(1, 0, 0, 40, 2, H);
        while (exp_q.size() > D) void'(exp_q.pop_back());
        n_cmp++;
        if (ovf !== 1'b1 || m_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got ovf=%b valid=%b required 1/1", ovf, m_valid); end
        n_cmp++;
        if (got.size() !== 0 || fd_cnt !== 0) begin n_bad++; $display("FAIL ovf_hold: got %0d beats %0d done required 0/0", got.size(), fd_cnt); end
        ready_mode = 0;
        wait_drain(500);
        n_cmp++;
        if (got.size() !== D) begin n_bad++; $display("FAIL ovf_count: got %0d required %0d", got.size(), D); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL ovf_beat[%0d]: got %h required %h", i, got[i], exp_q[i]); end
        end
        n_cmp++;
        if (fd_cnt !== 1 || ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_drained: got done=%0d ovf=%b required 1/1", fd_cnt, ovf); end
        clear_obs();
        drive_frame(0, 0, 0, 40, 2, H);
        n_cmp++;
        if (ovf !== 1'b0 || got.size() !== 0) begin n_bad++; $display("FAIL ovf_clear: got ovf=%b beats=%0d required 0/0", ovf, got.size()); end
    endtask

    task automatic test_timing_err;
        clear_obs(); ready_mode = 0;
        lens[2] = W - 1;
        mark_line = 2;
        drive_frame(0, 0, 0, 4, 4, H);
        mark_line = -1;
        n_cmp++;
        if (te_cnt !== 1) begin n_bad++; $display("FAIL terr_count: got %0d required 1", te_cnt); end
        n_cmp++;
        if (te_cyc - mark_cyc < 1 || te_cyc - mark_cyc > 3) begin
            n_bad++; $display("FAIL terr_when: got %0d cycles after de fall required 1..3", te_cyc - mark_cyc);
        end
        n_cmp++;
        if (got.size() !== 0 || fd_cnt !== 0) begin n_bad++; $display("FAIL terr_quiet: got %0d beats %0d done required 0/0", got.size(), fd_cnt); end
    endtask

    task automatic test_short_frame;
        int n_old;
        clear_obs(); ready_mode = 0;
        lens[5] = 3;
        drive_frame(1, 2, 2, 6, 6, 6);
        model_frame(1, 2, 2, 6, 6, 6);
        n_old = exp_q.size();
        lens[5] = W;
        drive_frame(1, 10, 10, 4, 2, H);
        model_frame(1, 10, 10, 4, 2, H);
        wait_drain(3000);
        n_cmp++;
        if (got.size() !== n_old + 8) begin n_bad++; $display("FAIL short_count: got %0d required %0d", got.size(), n_old + 8); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL short_beat[%0d]: got %h required %h", i, got[i], exp_q[i]); end
        end
        n_cmp++;
        if (fd_cnt !== 1) begin n_bad++; $display("FAIL short_done: got %0d required 1", fd_cnt); end
    endtask

    task automatic test_reset_mid;
        clear_obs(); ready_mode = 1;
        lens[4] = 4;
        drive_frame(1, 5, 3, 8, 4, 5);
        n_cmp++;
        if (m_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre: got valid=%b required 1", m_valid); end
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({m_valid, m_sof, m_eol, frame_done, ovf, timing_err, m_data} !== 30'b0) begin
                n_bad++; $display("FAIL rstmid_out%0d: got %h required 0", k,
                                  {m_valid, m_sof, m_eol, frame_done, ovf, timing_err, m_data});
            end
        end
        step;
        rst_n = 1'b1;
        repeat (3) step;
        clear_obs(); ready_mode = 2;
        drive_frame(1, 5, 3, 8, 4, H);
        model_frame(1, 5, 3, 8, 4, H);
        wait_drain(3000);
        n_cmp++;
        if (got.size() !== 32) begin n_bad++; $display("FAIL rstmid_count: got %0d required 32", got.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL rstmid_beat[%0d]: got %h required %h", i, got[i], exp_q[i]); end
        end
        n_cmp++;
        if (fd_cnt !== 1 || ovf !== 1'b0) begin n_bad++; $display("FAIL rstmid_status: got done=%0d ovf=%b required 1/0", fd_cnt, ovf); end
    endtask

    task automatic test_stability;
        n_cmp++;
        if (stab_bad !== 0) begin n_bad++; $display("FAIL hold_stable: got %0d changes while stalled required 0", stab_bad); end
    endtask

    initial begin
        for (int i = 0; i < H; i++) lens[i] = W;
        test_reset();
        test_basic();
        test_random();
        test_clip();
        test_overflow();
        test_timing_err();
        test_short_frame();
        test_reset_mid();
        test_stability();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
